// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: size encodings,
// FSM state codes and byte-lane geometry.
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [0:0] LSU_IDLE      = 1'b0;
   localparam logic [0:0] LSU_RMW_WRITE = 1'b1;

   localparam int LANE_W = 8;
   localparam int LANES  = 4;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension, store
// lane merge into the old word, and alignment checking.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic [1:0]        lane_i,
   input  logic [DATA_W-1:0] rd_word_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] merge_o,
   output logic              misaligned_o
);

   logic [4:0]        sh;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] ins;

   assign sh      = {lane_i, 3'b000};
   assign shifted = rd_word_i >> sh;

   always_comb begin
      load_o       = '0;
      mask         = '0;
      ins          = '0;
      misaligned_o = 1'b0;
      unique case (size_i)
         SIZE_BYTE: begin
            load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            mask   = 32'h0000_00FF << sh;
            ins    = {24'b0, st_data_i[7:0]} << sh;
         end
         SIZE_HALF: begin
            load_o       = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            mask         = 32'h0000_FFFF << sh;
            ins          = {16'b0, st_data_i[15:0]} << sh;
            misaligned_o = lane_i[0];
         end
         SIZE_WORD: begin
            load_o       = rd_word_i;
            mask         = '1;
            ins          = st_data_i;
            misaligned_o = |lane_i;
         end
         default: misaligned_o = 1'b1;
      endcase
   end

   // Old lanes outside the mask survive the read-modify-write
   assign merge_o = (rd_word_i & ~mask) | (ins & mask);

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end: byte/half/word loads and stores onto a
// word-only memory, with two-cycle read-modify-write for sub-words.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              misaligned
);

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              load_valid_q, load_valid_d;
   logic              mis_q, mis_d;
   logic              wr, stall_c;
   logic [DATA_W-1:0] al_load, al_merge;
   logic              al_mis;

   lsu_lane_align #(.DATA_W(DATA_W)) u_align (
      .size_i      (req_size),
      .signed_i    (req_signed),
      .lane_i      (address[1:0]),
      .rd_word_i   (mem_read_data),
      .st_data_i   (write_data),
      .load_o      (al_load),
      .merge_o     (al_merge),
      .misaligned_o(al_mis)
   );

   always_comb begin
      state_d        = state_q;
      merge_d        = merge_q;
      load_data_d    = load_data_q;
      load_valid_d   = 1'b0;
      mis_d          = 1'b0;
      wr             = 1'b0;
      stall_c        = 1'b0;
      mem_write_data = write_data;
      if (state_q == LSU_RMW_WRITE) begin
         wr             = 1'b1;
         mem_write_data = merge_q;
         state_d        = LSU_IDLE;
      end else if (req_valid) begin
         if (al_mis) begin
            mis_d = 1'b1;
         end else if (!req_write) begin
            load_data_d  = al_load;
            load_valid_d = 1'b1;
         end else if (req_size == SIZE_WORD) begin
            wr = 1'b1;
         end else begin
            stall_c = 1'b1;
            merge_d = al_merge;
            state_d = LSU_RMW_WRITE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= LSU_IDLE;
         merge_q      <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         merge_q      <= merge_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mis_q        <= mis_d;
      end
   end

   assign mem_address = {address[ADDR_W-1:2], 2'b00};
   assign mem_write   = wr & ~reset;
   assign stall       = stall_c & ~reset;
   assign load_data   = load_data_q;
   assign load_valid  = load_valid_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory
// preset with word i = i.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] address, write_data;
   logic        mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid, misaligned;

   logic [31:0] mem [0:15];
   int          wr_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          w0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .address       (address),
      .write_data    (write_data),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .stall         (stall),
      .load_data     (load_data),
      .load_valid    (load_valid),
      .misaligned    (misaligned)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[5:2]];

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_address[5:2]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic v, input logic w, input logic [1:0] sz,
                      input logic s, input logic [31:0] a,
                      input logic [31:0] wd);
      req_valid  = v;
      req_write  = w;
      req_size   = sz;
      req_signed = s;
      address    = a;
      write_data = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = i;
      reset = 1'b1;
      idle();
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_memwr", {31'b0, mem_write}, 32'd0);
      chk("rst_lvalid", {31'b0, load_valid}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      chk("rst_ldata", load_data, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // word load @12
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'd12, 32'd0);
      #1;
      chk("wl_stall", {31'b0, stall}, 32'd0);
      chk("wl_memwr", {31'b0, mem_write}, 32'd0);
      chk("wl_addr", mem_address, 32'd12);
      tick();
      idle();
      chk("wl_data", load_data, 32'd3);
      chk("wl_valid", {31'b0, load_valid}, 32'd1);
      tick();
      chk("wl_pulse", {31'b0, load_valid}, 32'd0);

      // byte store 0xAB @21
      w0 = wr_cnt;
      req(1'b1, 1'b1, 2'b00, 1'b0, 32'd21, 32'h0000_00AB);
      #1;
      chk("bs_stall1", {31'b0, stall}, 32'd1);
      chk("bs_memwr1", {31'b0, mem_write}, 32'd0);
      tick();
      chk("bs_stall2", {31'b0, stall}, 32'd0);
      chk("bs_memwr2", {31'b0, mem_write}, 32'd1);
      chk("bs_wdata", mem_write_data, 32'h0000_AB05);
      tick();
      idle();
      chk("bs_mem", mem[5], 32'h0000_AB05);
      chk("bs_wrcnt", wr_cnt - w0, 32'd1);
      chk("bs_ldata", load_data, 32'd3);
      chk("bs_lvalid", {31'b0, load_valid}, 32'd0);

      // byte loads @21 back-to-back, signed then unsigned
      req(1'b1, 1'b0, 2'b00, 1'b1, 32'd21, 32'd0);
      tick();
      chk("bl_s", load_data, 32'hFFFF_FFAB);
      req(1'b1, 1'b0, 2'b00, 1'b0, 32'd21, 32'd0);
      tick();
      idle();
      chk("bl_u", load_data, 32'h0000_00AB);
      chk("bl_u_valid", {31'b0, load_valid}, 32'd1);
      tick();

      // half store 0x1234 @22, then signed half load
      req(1'b1, 1'b1, 2'b01, 1'b0, 32'd22, 32'h0000_1234);
      #1;
      chk("hs_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("hs_wdata", mem_write_data, 32'h1234_AB05);
      tick();
      chk("hs_mem", mem[5], 32'h1234_AB05);
      req(1'b1, 1'b0, 2'b01, 1'b1, 32'd22, 32'd0);
      tick();
      idle();
      chk("hl_s", load_data, 32'h0000_1234);
      tick();

      // word store then immediate word load of the same word
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'd28, 32'hDEAD_BEEF);
      #1;
      chk("ws_memwr", {31'b0, mem_write}, 32'd1);
      chk("ws_stall", {31'b0, stall}, 32'd0);
      tick();
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'd28, 32'd0);
      tick();
      idle();
      chk("ws_readback", load_data, 32'hDEAD_BEEF);
      tick();

      // misaligned: word store @14
      w0 = wr_cnt;
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'd14, 32'hFFFF_FFFF);
      #1;
      chk("m1_memwr", {31'b0, mem_write}, 32'd0);
      chk("m1_stall", {31'b0, stall}, 32'd0);
      tick();
      idle();
      chk("m1_mis", {31'b0, misaligned}, 32'd1);
      chk("m1_lvalid", {31'b0, load_valid}, 32'd0);
      tick();
      chk("m1_pulse", {31'b0, misaligned}, 32'd0);

      // misaligned: half load @21
      req(1'b1, 1'b0, 2'b01, 1'b1, 32'd21, 32'd0);
      tick();
      idle();
      chk("m2_mis", {31'b0, misaligned}, 32'd1);
      chk("m2_lvalid", {31'b0, load_valid}, 32'd0);
      chk("m2_ldata", load_data, 32'hDEAD_BEEF);
      tick();

      // reserved size @0
      req(1'b1, 1'b1, 2'b11, 1'b0, 32'd0, 32'h5555_5555);
      #1;
      chk("m3_memwr", {31'b0, mem_write}, 32'd0);
      tick();
      idle();
      chk("m3_mis", {31'b0, misaligned}, 32'd1);
      chk("m_wrcnt", wr_cnt - w0, 32'd0);
      chk("m_mem0", mem[0], 32'd0);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'd12, 32'd0);
      tick();
      idle();
      chk("m_word12", load_data, 32'd3);
      tick();

      // reset during RMW_WRITE of a byte store @20
      w0 = wr_cnt;
      req(1'b1, 1'b1, 2'b00, 1'b0, 32'd20, 32'h0000_0077);
      tick();
      chk("r_inrmw", {31'b0, mem_write}, 32'd1);
      reset = 1'b1;
      #1;
      chk("r_stall", {31'b0, stall}, 32'd0);
      chk("r_memwr", {31'b0, mem_write}, 32'd0);
      chk("r_ldata", load_data, 32'd0);
      chk("r_lvalid", {31'b0, load_valid}, 32'd0);
      chk("r_mis", {31'b0, misaligned}, 32'd0);
      tick();
      chk("r_mem", mem[5], 32'h1234_AB05);
      chk("r_wrcnt", wr_cnt - w0, 32'd0);
      idle();
      reset = 1'b0;
      tick();

      // back in IDLE: load, then a byte store must stall first
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'd20, 32'd0);
      #1;
      chk("p_stall0", {31'b0, stall}, 32'd0);
      tick();
      chk("p_ldata", load_data, 32'h1234_AB05);
      req(1'b1, 1'b1, 2'b00, 1'b0, 32'd20, 32'h0000_0077);
      #1;
      chk("p_stall1", {31'b0, stall}, 32'd1);
      tick();
      tick();
      idle();
      chk("p_mem", mem[5], 32'h1234_AB77);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
